// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback stage wrapped around the integer ALU.
// Takes one SPARC v8 format-3 arithmetic word at a time, maps op3 onto the
// ALU operation code, feeds operands from the register file, and commits
// rd/ICC/Y. ALU divide-by-zero / tag-overflow flags become trap pulses,
// each followed by the matching ALU clear-handler operation.
module alu_sequencer #(
    parameter int XLEN = 32,
    parameter int OPW  = 7
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_inst,
    input  logic            i_inst_valid,
    output logic            o_inst_ready,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_wr_en,
    output logic [4:0]      o_wr_addr,
    output logic [XLEN-1:0] o_wr_data,
    output logic [XLEN-1:0] o_alu_r1,
    output logic [XLEN-1:0] o_alu_r2,
    output logic [OPW-1:0]  o_alu_op,
    output logic            o_alu_operate,
    output logic [3:0]      o_alu_icc_in,
    output logic [XLEN-1:0] o_alu_y_in,
    input  logic [XLEN-1:0] i_alu_rd,
    input  logic [3:0]      i_alu_icc_out,
    input  logic [XLEN-1:0] i_alu_y_out,
    input  logic            i_alu_dbz,
    input  logic            i_alu_tof,
    output logic [3:0]      o_icc,
    output logic [XLEN-1:0] o_y,
    output logic            o_done,
    output logic            o_trap,
    output logic [1:0]      o_trap_type
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_CLEAR} state_t;

    typedef struct packed {
        logic           legal;
        logic [OPW-1:0] op;
        logic           shift;  // SLL/SRL/SRA: shift count is rs2[4:0]
        logic           cc;     // commits ICC
        logic           wr_y;   // commits Y
    } dec_t;

    localparam logic [OPW-1:0] OP_CLR_DBZ = OPW'(35);
    localparam logic [OPW-1:0] OP_CLR_TOF = OPW'(36);
    localparam logic [1:0]     TT_DBZ     = 2'b01;
    localparam logic [1:0]     TT_TOF     = 2'b10;
    localparam logic [1:0]     TT_ILL     = 2'b11;

    // op3 -> ALU operation code plus commit attributes
    function automatic dec_t decode(input logic [5:0] op3);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op3)
            6'h00: d.op = OPW'(14);
            6'h01: d.op = OPW'(1);
            6'h02: d.op = OPW'(3);
            6'h03: d.op = OPW'(7);
            6'h04: d.op = OPW'(20);
            6'h06: d.op = OPW'(5);
            6'h07: d.op = OPW'(9);
            6'h08: d.op = OPW'(16);
            6'h0A: d.op = OPW'(27);
            6'h0B: d.op = OPW'(31);
            6'h0C: d.op = OPW'(22);
            6'h0E: d.op = OPW'(29);
            6'h0F: d.op = OPW'(33);
            6'h10: d.op = OPW'(15);
            6'h11: d.op = OPW'(2);
            6'h12: d.op = OPW'(4);
            6'h13: d.op = OPW'(8);
            6'h14: d.op = OPW'(21);
            6'h16: d.op = OPW'(6);
            6'h17: d.op = OPW'(10);
            6'h18: d.op = OPW'(17);
            6'h1A: d.op = OPW'(28);
            6'h1B: d.op = OPW'(32);
            6'h1C: d.op = OPW'(23);
            6'h1E: d.op = OPW'(30);
            6'h1F: d.op = OPW'(34);
            6'h20: d.op = OPW'(18);
            6'h21: d.op = OPW'(24);
            6'h22: d.op = OPW'(19);
            6'h23: d.op = OPW'(25);
            6'h24: d.op = OPW'(26);
            6'h25: d.op = OPW'(11);
            6'h26: d.op = OPW'(12);
            6'h27: d.op = OPW'(13);
            default: d.legal = 1'b0;
        endcase
        d.shift = (op3 == 6'h25) || (op3 == 6'h26) || (op3 == 6'h27);
        d.cc    = op3[4] || ((op3 >= 6'h20) && (op3 <= 6'h24));
        d.wr_y  = (op3 == 6'h0A) || (op3 == 6'h0B) || (op3 == 6'h1A) ||
                  (op3 == 6'h1B) || (op3 == 6'h24);
        return d;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_inst;
    logic            r_ready;
    logic            r_wr_en;
    logic [4:0]      r_wr_addr;
    logic [XLEN-1:0] r_wr_data;
    logic [XLEN-1:0] r_alu_r1;
    logic [XLEN-1:0] r_alu_r2;
    logic [OPW-1:0]  r_alu_op;
    logic            r_alu_operate;
    logic [3:0]      r_icc;
    logic [XLEN-1:0] r_y;
    logic            r_done;
    logic            r_trap;
    logic [1:0]      r_trap_type;

    logic [31:0]     w_inst;
    logic            w_ready;
    logic            w_wr_en;
    logic [4:0]      w_wr_addr;
    logic [XLEN-1:0] w_wr_data;
    logic [XLEN-1:0] w_alu_r1;
    logic [XLEN-1:0] w_alu_r2;
    logic [OPW-1:0]  w_alu_op;
    logic            w_alu_operate;
    logic [3:0]      w_icc;
    logic [XLEN-1:0] w_y;
    logic            w_done;
    logic            w_trap;
    logic [1:0]      w_trap_type;

    dec_t            w_dec;
    logic            w_legal;
    logic            w_accept;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_simm;
    logic [XLEN-1:0] w_r2_raw;
    logic [XLEN-1:0] w_r2;

    // r_ready is only ever set while the next state is IDLE
    assign w_accept = r_ready && i_inst_valid;
    assign w_dec    = decode(r_inst[24:19]);
    assign w_legal  = (r_inst[31:30] == 2'b10) && w_dec.legal;
    assign w_rd     = r_inst[29:25];
    assign w_simm   = {{(XLEN-13){r_inst[12]}}, r_inst[12:0]};
    assign w_r2_raw = r_inst[13] ? w_simm : i_rs2_data;
    assign w_r2     = w_dec.shift ? {{(XLEN-5){1'b0}}, w_r2_raw[4:0]} : w_r2_raw;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_IDLE;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = (i_alu_dbz || i_alu_tof) ? S_CLEAR : S_IDLE;
            S_CLEAR:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_inst        = r_inst;
        w_ready       = (w_state_nxt == S_IDLE);
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_alu_r1      = r_alu_r1;
        w_alu_r2      = r_alu_r2;
        w_alu_op      = r_alu_op;
        w_alu_operate = 1'b0;
        w_icc         = r_icc;
        w_y           = r_y;
        w_done        = 1'b0;
        w_trap        = 1'b0;
        w_trap_type   = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_inst = i_inst;
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_alu_r1      = i_rs1_data;
                    w_alu_r2      = w_r2;
                    w_alu_op      = w_dec.op;
                    w_alu_operate = 1'b1;
                end else begin
                    w_trap        = 1'b1;
                    w_trap_type   = TT_ILL;
                end
            end
            S_WB: begin
                if (i_alu_dbz) begin
                    // dbz outranks tof when both flags are up
                    w_trap        = 1'b1;
                    w_trap_type   = TT_DBZ;
                    w_alu_op      = OP_CLR_DBZ;
                    w_alu_operate = 1'b1;
                end else if (i_alu_tof) begin
                    w_trap        = 1'b1;
                    w_trap_type   = TT_TOF;
                    w_alu_op      = OP_CLR_TOF;
                    w_alu_operate = 1'b1;
                end else begin
                    w_done    = 1'b1;
                    w_wr_en   = (w_rd != 5'd0);
                    w_wr_addr = w_rd;
                    w_wr_data = i_alu_rd;
                    if (w_dec.cc)   w_icc = i_alu_icc_out;
                    if (w_dec.wr_y) w_y   = i_alu_y_out;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_inst        <= '0;
            r_ready       <= 1'b1;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_alu_r1      <= '0;
            r_alu_r2      <= '0;
            r_alu_op      <= '0;
            r_alu_operate <= 1'b0;
            r_icc         <= '0;
            r_y           <= '0;
            r_done        <= 1'b0;
            r_trap        <= 1'b0;
            r_trap_type   <= 2'b00;
        end else begin
            r_inst        <= w_inst;
            r_ready       <= w_ready;
            r_wr_en       <= w_wr_en;
            r_wr_addr     <= w_wr_addr;
            r_wr_data     <= w_wr_data;
            r_alu_r1      <= w_alu_r1;
            r_alu_r2      <= w_alu_r2;
            r_alu_op      <= w_alu_op;
            r_alu_operate <= w_alu_operate;
            r_icc         <= w_icc;
            r_y           <= w_y;
            r_done        <= w_done;
            r_trap        <= w_trap;
            r_trap_type   <= w_trap_type;
        end
    end

    assign o_inst_ready  = r_ready;
    assign o_rs1_addr    = r_inst[18:14];
    assign o_rs2_addr    = r_inst[4:0];
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_alu_r1      = r_alu_r1;
    assign o_alu_r2      = r_alu_r2;
    assign o_alu_op      = r_alu_op;
    assign o_alu_operate = r_alu_operate;
    assign o_alu_icc_in  = r_icc;
    assign o_alu_y_in    = r_y;
    assign o_icc         = r_icc;
    assign o_y           = r_y;
    assign o_done        = r_done;
    assign o_trap        = r_trap;
    assign o_trap_type   = r_trap_type;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random + directed stimulus against a behavioural model
// of the sequencer, with a toy ALU and register file living in the bench.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, alu_r1, alu_r2;
    logic [6:0]  alu_op;
    logic        alu_operate;
    logic [3:0]  alu_icc_in;
    logic [31:0] alu_y_in;
    logic [31:0] alu_rd, alu_y_out;
    logic [3:0]  alu_icc_out;
    logic        alu_dbz, alu_tof;
    logic [3:0]  icc;
    logic [31:0] y;
    logic        done, trap;
    logic [1:0]  trap_type;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] rf [32];
    int          opmap [64];
    logic [3:0]  exp_icc;
    logic [31:0] exp_y;
    logic        inject_tof;

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  icc;
        logic [31:0] y;
        logic        dbz;
        logic        tof;
    } res_t;

    alu_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst(inst), .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
        .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_alu_r1(alu_r1), .o_alu_r2(alu_r2), .o_alu_op(alu_op),
        .o_alu_operate(alu_operate), .o_alu_icc_in(alu_icc_in), .o_alu_y_in(alu_y_in),
        .i_alu_rd(alu_rd), .i_alu_icc_out(alu_icc_out), .i_alu_y_out(alu_y_out),
        .i_alu_dbz(alu_dbz), .i_alu_tof(alu_tof),
        .o_icc(icc), .o_y(y), .o_done(done), .o_trap(trap), .o_trap_type(trap_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    // Toy ALU: a few real ops so the directed cases have meaningful numbers,
    // everything else a scramble so a wrong commit is visible.
    function automatic res_t alu_f(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] yi);
        res_t        r;
        logic [32:0] s;
        logic [63:0] p;
        r = '0;
        s = '0;
        p = '0;
        case (op)
            7'd14, 7'd15, 7'd24: begin
                s     = {1'b0, a} + {1'b0, b};
                r.rd  = s[31:0];
                r.icc = {s[31], s[31:0] == 32'd0, (a[31] == b[31]) && (s[31] != a[31]), s[32]};
                r.y   = ~yi;
                r.tof = (op == 7'd24) && ((a[1:0] | b[1:0]) != 2'b00);
            end
            7'd20, 7'd21, 7'd25: begin
                s     = {1'b0, a} - {1'b0, b};
                r.rd  = s[31:0];
                r.icc = {s[31], s[31:0] == 32'd0, (a[31] != b[31]) && (s[31] != a[31]), s[32]};
                r.y   = ~yi;
                r.tof = (op == 7'd25) && ((a[1:0] | b[1:0]) != 2'b00);
            end
            7'd1, 7'd2, 7'd3, 7'd4: begin
                r.rd  = (op <= 7'd2) ? (a & b) : (a | b);
                r.icc = {r.rd[31], r.rd == 32'd0, 2'b00};
                r.y   = ~yi;
            end
            7'd27, 7'd28: begin
                p     = {32'd0, a} * {32'd0, b};
                r.rd  = p[31:0];
                r.y   = p[63:32];
                r.icc = {r.rd[31], r.rd == 32'd0, 2'b00};
            end
            7'd29, 7'd30, 7'd33, 7'd34: begin
                r.dbz = (b == 32'd0);
                r.rd  = r.dbz ? 32'd0 : a / b;
                r.icc = {r.rd[31], r.rd == 32'd0, 2'b00};
                r.y   = yi;
            end
            default: begin
                r.rd  = a ^ {b[24:0], op};
                r.icc = op[3:0] ^ a[3:0];
                r.y   = a + b;
            end
        endcase
        return r;
    endfunction

    res_t alu_now;
    assign alu_now = alu_f(alu_op, alu_r1, alu_r2, alu_y_in);

    // ALU samples on the edge ending an operate cycle; flags are sticky
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_rd <= '0; alu_icc_out <= '0; alu_y_out <= '0; alu_dbz <= 1'b0; alu_tof <= 1'b0;
        end else if (alu_operate) begin
            if (alu_op == 7'd35)      alu_dbz <= 1'b0;
            else if (alu_op == 7'd36) alu_tof <= 1'b0;
            else begin
                alu_rd      <= alu_now.rd;
                alu_icc_out <= alu_now.icc;
                alu_y_out   <= alu_now.y;
                alu_dbz     <= alu_dbz | alu_now.dbz;
                alu_tof     <= alu_tof | alu_now.tof | inject_tof;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op3, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic i, input logic [12:0] lo);
        return {2'b10, rd, op3, rs1, i, lo};
    endfunction

    task automatic rand_rf();
        for (int k = 1; k < 32; k++) rf[k] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        rf[0] = 32'd0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 64'(inst_ready), 64'(1));
        chk({tag, "_ctl"}, 64'({rs1_addr, rs2_addr, wr_en, wr_addr, alu_op, alu_operate, alu_icc_in,
                                icc, done, trap, trap_type}), 64'(0));
        chk({tag, "_data"}, {wr_data, alu_r1}, 64'(0));
        chk({tag, "_data2"}, {alu_r2, alu_y_in}, 64'(0));
        chk({tag, "_y"}, 64'(y), 64'(0));
    endtask

    // Issue one instruction and follow it cycle by cycle; ends on a negedge.
    task automatic run_inst(input logic [31:0] ins, input bit hold);
        logic [5:0]  op3;
        logic [4:0]  rd;
        logic        legal, dz, tv, cc, wy;
        logic [6:0]  eop;
        logic [31:0] er1, er2;
        res_t        er;
        for (int k = 0; k < 20 && !inst_ready; k++) @(negedge clk);
        chk("ready_wait", 64'(inst_ready), 64'(1));
        op3   = ins[24:19];
        rd    = ins[29:25];
        legal = (ins[31:30] == 2'b10) && (opmap[op3] >= 0);
        eop   = 7'(opmap[op3]);
        er1   = rf[ins[18:14]];
        er2   = ins[13] ? {{19{ins[12]}}, ins[12:0]} : rf[ins[4:0]];
        if (op3 >= 6'h25 && op3 <= 6'h27) er2 = er2 & 32'h1F;
        er    = alu_f(eop, er1, er2, exp_y);
        dz    = alu_dbz | er.dbz;
        tv    = alu_tof | er.tof | inject_tof;
        cc    = op3[4] || (op3 >= 6'h20 && op3 <= 6'h24);
        wy    = (op3 == 6'h0A) || (op3 == 6'h0B) || (op3 == 6'h1A) || (op3 == 6'h1B) || (op3 == 6'h24);
        inst = ins;
        inst_valid = 1'b1;
        @(negedge clk);                                   // DECODE
        if (!hold) inst_valid = 1'b0;
        chk("dec_ready", 64'(inst_ready), 64'(0));
        chk("dec_addr", 64'({rs1_addr, rs2_addr}), 64'({ins[18:14], ins[4:0]}));
        chk("dec_quiet", 64'({done, trap, wr_en, alu_operate}), 64'(0));
        @(negedge clk);
        if (!legal) begin
            inst_valid = 1'b0;
            chk("ill_trap", 64'({trap, trap_type}), 64'(3'b111));
            chk("ill_quiet", 64'({wr_en, done, alu_operate}), 64'(0));
            chk("ill_ready", 64'(inst_ready), 64'(1));
            @(negedge clk);
            chk("ill_after", 64'({trap, inst_ready}), 64'(2'b01));
        end else begin                                    // EXEC
            chk("ex_op", 64'({alu_operate, alu_op}), 64'({1'b1, eop}));
            chk("ex_r1", 64'(alu_r1), 64'(er1));
            chk("ex_r2", 64'(alu_r2), 64'(er2));
            chk("ex_ccy", 64'({alu_icc_in, alu_y_in}), 64'({exp_icc, exp_y}));
            chk("ex_ready", 64'({inst_ready, trap, done}), 64'(0));
            @(negedge clk);                               // WB
            chk("wb_quiet", 64'({alu_operate, done, trap, wr_en, inst_ready}), 64'(0));
            @(negedge clk);
            inst_valid = 1'b0;
            if (dz || tv) begin                           // CLEAR
                chk("trap", 64'({trap, trap_type}), 64'({1'b1, dz ? 2'b01 : 2'b10}));
                chk("clr_op", 64'({alu_operate, alu_op}), 64'({1'b1, dz ? 7'd35 : 7'd36}));
                chk("clr_quiet", 64'({wr_en, done}), 64'(0));
                chk("clr_ccy", 64'({icc, y}), 64'({exp_icc, exp_y}));
                @(negedge clk);
                chk("clr_after", 64'({alu_operate, trap, inst_ready}), 64'(3'b001));
            end else begin
                if (cc) exp_icc = er.icc;
                if (wy) exp_y   = er.y;
                chk("done", 64'({done, wr_en, trap, trap_type, alu_operate}),
                    64'({1'b1, rd != 5'd0, 4'b0000}));
                if (rd != 5'd0) chk("wr", 64'({wr_addr, wr_data}), 64'({rd, er.rd}));
                chk("commit_ccy", 64'({icc, y}), 64'({exp_icc, exp_y}));
                chk("wb_ready", 64'(inst_ready), 64'(1));
                @(negedge clk);
                chk("pulse_end", 64'({done, wr_en, inst_ready}), 64'(3'b001));
            end
        end
    endtask

    initial begin
        logic [31:0] ins;
        for (int k = 0; k < 64; k++) opmap[k] = -1;
        opmap['h00] = 14; opmap['h01] = 1;  opmap['h02] = 3;  opmap['h03] = 7;
        opmap['h04] = 20; opmap['h06] = 5;  opmap['h07] = 9;  opmap['h08] = 16;
        opmap['h0A] = 27; opmap['h0B] = 31; opmap['h0C] = 22; opmap['h0E] = 29;
        opmap['h0F] = 33;
        opmap['h10] = 15; opmap['h11] = 2;  opmap['h12] = 4;  opmap['h13] = 8;
        opmap['h14] = 21; opmap['h16] = 6;  opmap['h17] = 10; opmap['h18] = 17;
        opmap['h1A] = 28; opmap['h1B] = 32; opmap['h1C] = 23; opmap['h1E] = 30;
        opmap['h1F] = 34;
        opmap['h20] = 18; opmap['h21] = 24; opmap['h22] = 19; opmap['h23] = 25;
        opmap['h24] = 26; opmap['h25] = 11; opmap['h26] = 12; opmap['h27] = 13;
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        rst = 1'b0; inst = '0; inst_valid = 1'b0; inject_tof = 1'b0;
        exp_icc = '0; exp_y = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst = 1'b1;
        @(negedge clk);

        // ADDcc 5 + 7 -> r3
        rand_rf(); rf[1] = 32'd5; rf[2] = 32'd7;
        run_inst(mk(6'h10, 5'd3, 5'd1, 1'b0, 13'd2), 1'b0);
        // SUBcc with simm13 = 1 and simm13 = -1
        rand_rf(); rf[1] = 32'd1;
        run_inst(mk(6'h14, 5'd4, 5'd1, 1'b1, 13'd1), 1'b0);
        run_inst(mk(6'h14, 5'd4, 5'd1, 1'b1, 13'h1FFF), 1'b0);
        // UDIV by zero
        rand_rf(); rf[1] = 32'd100; rf[6] = 32'd0;
        run_inst(mk(6'h0E, 5'd5, 5'd1, 1'b0, 13'd6), 1'b0);
        // UMUL 0xFFFFFFFF * 2
        rand_rf(); rf[1] = 32'hFFFFFFFF; rf[2] = 32'd2;
        run_inst(mk(6'h0A, 5'd7, 5'd1, 1'b0, 13'd2), 1'b0);
        // all-zero word is not format 3
        run_inst(32'd0, 1'b0);
        // OR into g0
        rand_rf();
        run_inst(mk(6'h02, 5'd0, 5'd1, 1'b0, 13'd2), 1'b0);
        // shift count from immediate is masked to 5 bits
        run_inst(mk(6'h25, 5'd3, 5'd1, 1'b1, 13'h1FE3), 1'b0);
        // inst_valid held high through the whole operation
        run_inst(mk(6'h00, 5'd9, 5'd1, 1'b0, 13'd2), 1'b1);
        // dbz and tof together: dbz first, then the leftover tof traps the next one
        rand_rf(); rf[6] = 32'd0;
        inject_tof = 1'b1;
        run_inst(mk(6'h0E, 5'd5, 5'd1, 1'b0, 13'd6), 1'b0);
        inject_tof = 1'b0;
        run_inst(mk(6'h00, 5'd5, 5'd1, 1'b0, 13'd2), 1'b0);

        for (int n = 0; n < 200; n++) begin
            rand_rf();
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[31:30] = 2'b10;
            if ($urandom_range(0, 3) != 0) ins[24:19] = 6'($urandom_range(0, 'h27));
            run_inst(ins, $urandom_range(0, 9) == 0);
        end

        // reset while in EXEC aborts with nothing committed
        rand_rf();
        inst = mk(6'h10, 5'd3, 5'd1, 1'b0, 13'd2);
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_exec", 64'(alu_operate), 64'(1));
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        @(negedge clk);
        chk("mid_rst_hold", 64'({done, wr_en, trap, inst_ready}), 64'(4'b0001));
        rst = 1'b1;
        exp_icc = '0; exp_y = '0;
        @(negedge clk);
        chk("post_rst_idle", 64'({done, wr_en, trap, alu_operate, inst_ready}), 64'(5'b00001));
        rand_rf();
        run_inst(mk(6'h10, 5'd8, 5'd2, 1'b1, 13'd3), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage wrapped around the integer ALU.
- Accepts one SPARC v8 format-3 arithmetic instruction word at a time over a valid/ready handshake. Decodes op3 into the ALU's operation code, reads operands from the register file, pulses the ALU, and commits rd/ICC/Y.
- Owns the architectural ICC and Y registers. Converts ALU divide-by-zero and tag-overflow flags into trap pulses, then issues the matching ALU clear-handler operation.

Parameters:
- XLEN, 32, datapath width (fixed by ALU).
- OPW, 7, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- inst  in  32  instruction word.
- inst_valid  in  1  inst is presented.
- inst_ready  out  1  sequencer can accept.
- rs1_addr, rs2_addr  out  5 each  register file read addresses; combinational reads.
- rs1_data, rs2_data  in  32 each  register file read data.
- wr_en  out  1  register file write strobe.
- wr_addr  out  5  register file write address.
- wr_data  out  32  register file write data.
- alu_r1, alu_r2  out  32 each  ALU operands.
- alu_op  out  7  ALU operation code.
- alu_operate  out  1  ALU enable.
- alu_icc_in  out  4  current ICC (NZVC) to ALU.
- alu_y_in  out  32  current Y to ALU.
- alu_rd  in  32  ALU result.
- alu_icc_out  in  4  ALU ICC result.
- alu_y_out  in  32  ALU Y result.
- alu_dbz  in  1  ALU divide_by_zero, sticky until cleared.
- alu_tof  in  1  ALU tag_overflow, sticky until cleared.
- icc  out  4  architectural ICC.
- y  out  32  architectural Y.
- done  out  1  one-cycle pulse when an instruction retires.
- trap  out  1  one-cycle trap pulse.
- trap_type  out  2  01 = divide by zero, 10 = tag overflow, 11 = illegal instruction.

Behaviour:
- Reset (rst low, any state): state returns to IDLE. All outputs are 0 except inst_ready, which is 1. icc = 0, y = 0, latched instruction = 0.
- All outputs are registered.
- alu_icc_in = icc and alu_y_in = y at all times.
- IDLE:
  - inst_ready = 1.
  - On inst_valid & inst_ready: latch inst, drop inst_ready, go DECODE. A new instruction is never accepted until retire or trap completes.
- DECODE (1 cycle):
  - rs1_addr = inst[18:14]; rs2_addr = inst[4:0].
  - alu_r1 = rs1_data.
  - alu_r2 = sign-extended inst[12:0] if inst[13] is set, else rs2_data.
  - Shift ops (SLL/SRL/SRA): alu_r2 is masked to bits [4:0].
  - If inst[31:30] != 2'b10 or op3 is unmapped: trap = 1, trap_type = 11, go IDLE; no writeback.
  - Otherwise register alu_op, assert alu_operate, go EXEC.
- op3 to alu_op mapping:
  - 00 to 1 (ADD); 01 to 1 (AND); 02 to 3; 03 to 7; 04 to 20; 06 to 5; 07 to 9; 08 to 16; 0A to 27; 0B to 31; 0C to 22; 0E to 29; 0F to 33.
  - 10 to 15; 11 to 2; 12 to 4; 13 to 8; 14 to 21; 16 to 6; 17 to 10; 18 to 17; 1A to 28; 1B to 32; 1C to 23; 1E to 30; 1F to 34.
  - 20 to 18; 21 to 24; 22 to 19; 23 to 25; 24 to 26; 25 to 11; 26 to 12; 27 to 13.
  - Correction to the first entry above: op3 00 maps to 14 (ADD); op3 01 maps to 1 (AND).
  - All other op3 values are illegal.
- EXEC (1 cycle):
  - alu_operate = 1; ALU samples at the end of this cycle.
  - Go WB.
- WB (ALU outputs valid; alu_operate = 0):
  - If alu_dbz: trap = 1, trap_type = 01, go CLEAR with alu_op = 35.
  - Else if alu_tof: trap = 1, trap_type = 10, go CLEAR with alu_op = 36.
  - If both are set, dbz wins.
  - Else commit and pulse done = 1, then go IDLE:
    - wr_en = 1 only when rd (inst[29:25]) != 0; writes to g0 are suppressed. wr_addr = rd, wr_data = alu_rd.
    - icc <= alu_icc_out only for cc ops: op3[4] set, or op3 in 20–24.
    - y <= alu_y_out only for op3 0A, 0B, 1A, 1B, 24.
- CLEAR (1 cycle):
  - alu_operate = 1 with the handler code; no writeback, icc and y unchanged.
  - Go IDLE.
- Latency: accept to done is 3 cycles (DECODE, EXEC, WB).
- wr_en, done and trap are single-cycle pulses.
- inst_valid is ignored outside IDLE.
- Reset asserted mid-operation aborts the operation with no partial commit.

Test Plan:
- ADDcc r1 = 5, r2 = 7, rd = 3 → done 3 cycles after accept; wr_en = 1, wr_addr = 3, wr_data = 12; icc = 0000.
- SUBcc simm13 = 1 with rs1_data = 1 → alu_r2 = 1, wr_data = 0, icc = 0100. Same op with simm13 = 0x1FFF → alu_r2 = 0xFFFFFFFF.
- UDIV with r2 = 0 (ALU asserts dbz) → trap = 1, trap_type = 01; next cycle alu_op = 35 with alu_operate = 1; wr_en never asserted; icc and y unchanged.
- UMUL 0xFFFFFFFF × 2 → wr_data = 0xFFFFFFFE, y = 1; icc unchanged.
- inst = 0x00000000 → trap_type = 11 one cycle after accept; inst_ready = 1 on the following cycle.
- OR with rd = 0 → done = 1 and wr_en = 0. Hold inst_valid high during EXEC → no second accept until IDLE. Pull rst low in EXEC → IDLE with all outputs 0 and inst_ready = 1.
